// File: rtl/cascaded_pwm_modulator.sv
// Level-shifted triangular-carrier PWM for a two-H-bridge 5-level inverter.
// Triangle carrier, double-edge reference sample/hold, four band
// comparators, level decode and four dead-time-protected complementary legs.
module cascaded_pwm_modulator #(
  parameter int DATA_WIDTH    = 16,
  parameter int CARRIER_WIDTH = 14,
  parameter int DT_WIDTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] ref_in,
  input  logic [CARRIER_WIDTH-1:0]     carrier_step,
  input  logic [DT_WIDTH-1:0]          deadtime,
  output logic [7:0]                   pwm_out,
  output logic signed [2:0]            level_out,
  output logic                         carrier_sync
);

  localparam int CMP_W = (DATA_WIDTH > CARRIER_WIDTH + 2) ? DATA_WIDTH : CARRIER_WIDTH + 2;

  typedef enum logic [2:0] {
    LEG_OFF,
    LEG_HIGH_ON,
    LEG_LOW_ON,
    LEG_DT_TO_HIGH,
    LEG_DT_TO_LOW
  } leg_state_e;

  logic [CARRIER_WIDTH-1:0]     carrier_cnt_q, carrier_cnt_d;
  logic [CARRIER_WIDTH:0]       carrier_sum;
  logic                         dir_up_q, dir_up_d;
  logic                         valley_d;
  logic                         turn;
  logic signed [DATA_WIDTH-1:0] ref_q;
  logic [CMP_W-1:0]             ref_biased;
  logic [3:0]                   comp;
  logic [2:0]                   band_count;
  logic [3:0]                   leg_tgt_high;
  leg_state_e                   leg_q [4];
  leg_state_e                   leg_d [4];
  logic [DT_WIDTH-1:0]          tmr_q [4];
  logic [DT_WIDTH-1:0]          tmr_d [4];

  // Extra carry bit keeps the up-count from wrapping before the peak test.
  assign carrier_sum = {1'b0, carrier_cnt_q} + {1'b0, carrier_step};

  // Triangle carrier next state: clamp and turn at the peak and the valley.
  always_comb begin
    carrier_cnt_d = carrier_cnt_q;
    dir_up_d      = dir_up_q;
    valley_d      = 1'b0;
    turn          = 1'b0;
    if (dir_up_q) begin
      if (carrier_sum >= {1'b0, {CARRIER_WIDTH{1'b1}}}) begin
        carrier_cnt_d = '1;
        dir_up_d      = 1'b0;
        turn          = 1'b1;
      end else begin
        carrier_cnt_d = carrier_sum[CARRIER_WIDTH-1:0];
      end
    end else begin
      if (carrier_cnt_q <= carrier_step) begin
        carrier_cnt_d = '0;
        dir_up_d      = 1'b1;
        valley_d      = 1'b1;
        turn          = 1'b1;
      end else begin
        carrier_cnt_d = carrier_cnt_q - carrier_step;
      end
    end
  end

  // Offset-binary reference: flipping the sign bit adds half of full scale.
  assign ref_biased = CMP_W'({~ref_q[DATA_WIDTH-1], ref_q[DATA_WIDTH-2:0]});

  // Band k carrier sits at k*2^CARRIER_WIDTH + carrier; strict compare per band.
  always_comb begin
    comp = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      comp[k] = ref_biased > CMP_W'({2'(k), carrier_cnt_q});
    end
  end

  assign band_count = {2'b00, comp[0]} + {2'b00, comp[1]} + {2'b00, comp[2]} + {2'b00, comp[3]};

  // Carrier, reference sample/hold and level registers; disable acts as reset.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      carrier_cnt_q <= '0;
      dir_up_q      <= 1'b1;
      ref_q         <= '0;
      level_out     <= '0;
      carrier_sync  <= 1'b0;
    end else begin
      carrier_cnt_q <= carrier_cnt_d;
      dir_up_q      <= dir_up_d;
      carrier_sync  <= valley_d;
      if (turn) begin
        ref_q <= ref_in;
      end
      level_out     <= band_count - 3'd2;
    end
  end

  // Level to per-leg target: H1 follows the sign, H2 only engages at +/-2.
  always_comb begin
    leg_tgt_high[0] = level_out > 3'sd0;
    leg_tgt_high[1] = level_out < 3'sd0;
    leg_tgt_high[2] = level_out == 3'sd2;
    leg_tgt_high[3] = level_out == -3'sd2;
  end

  // Leg FSM next state: any change of target restarts a full dead-time interval.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      leg_d[i] = leg_q[i];
      tmr_d[i] = tmr_q[i];
      case (leg_q[i])
        LEG_OFF: begin
          leg_d[i] = leg_tgt_high[i] ? LEG_DT_TO_HIGH : LEG_DT_TO_LOW;
          tmr_d[i] = deadtime;
        end
        LEG_HIGH_ON: begin
          if (!leg_tgt_high[i]) begin
            leg_d[i] = LEG_DT_TO_LOW;
            tmr_d[i] = deadtime;
          end
        end
        LEG_LOW_ON: begin
          if (leg_tgt_high[i]) begin
            leg_d[i] = LEG_DT_TO_HIGH;
            tmr_d[i] = deadtime;
          end
        end
        LEG_DT_TO_HIGH: begin
          if (!leg_tgt_high[i]) begin
            leg_d[i] = LEG_DT_TO_LOW;
            tmr_d[i] = deadtime;
          end else if (tmr_q[i] == '0) begin
            leg_d[i] = LEG_HIGH_ON;
          end else begin
            tmr_d[i] = tmr_q[i] - 1'b1;
          end
        end
        LEG_DT_TO_LOW: begin
          if (leg_tgt_high[i]) begin
            leg_d[i] = LEG_DT_TO_HIGH;
            tmr_d[i] = deadtime;
          end else if (tmr_q[i] == '0) begin
            leg_d[i] = LEG_LOW_ON;
          end else begin
            tmr_d[i] = tmr_q[i] - 1'b1;
          end
        end
        default: leg_d[i] = LEG_OFF;
      endcase
    end
  end

  // Leg state and dead-time timer registers.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (rst || !enable) begin
        leg_q[i] <= LEG_OFF;
        tmr_q[i] <= '0;
      end else begin
        leg_q[i] <= leg_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

  // Gate decode: only a settled ON state drives a gate, so a leg never shoots through.
  always_comb begin
    pwm_out = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      pwm_out[2*i]   = leg_q[i] == LEG_HIGH_ON;
      pwm_out[2*i+1] = leg_q[i] == LEG_LOW_ON;
    end
  end

endmodule

// File: tb/tb_cascaded_pwm_modulator.sv
// Self-checking bench for cascaded_pwm_modulator: a timestamp-based
// behavioural model checked every cycle, plus hand-computed scenario checks.
module tb_cascaded_pwm_modulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [15:0] ref_in;
  logic [13:0]        carrier_step;
  logic [7:0]         deadtime;
  logic [7:0]         pwm_out;
  logic signed [2:0]  level_out;
  logic               carrier_sync;

  int checks = 0;
  int failures = 0;

  cascaded_pwm_modulator #(
    .DATA_WIDTH(16),
    .CARRIER_WIDTH(14),
    .DT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .ref_in(ref_in),
    .carrier_step(carrier_step),
    .deadtime(deadtime),
    .pwm_out(pwm_out),
    .level_out(level_out),
    .carrier_sync(carrier_sync)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Legs are modelled by timestamps: the edge at which a leg last started
  // heading to a new target and the dead time captured then.
  int m_tri, m_refq, m_lvl, m_L, m_u, m_step;
  bit m_up, m_sync, m_turn, model_valid;
  int head [4];
  int tchg [4];
  int tdt [4];
  int mtgt [4];
  int edge_n = 0;

  initial begin
    model_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      head[i] = -1;
      tchg[i] = 0;
      tdt[i]  = 0;
    end
  end

  always @(posedge clk) begin
    edge_n++;
    if (rst || !enable) begin
      m_tri = 0; m_up = 1'b1; m_refq = 0; m_lvl = 0; m_sync = 1'b0;
      for (int i = 0; i < 4; i++) head[i] = -1;
    end else begin
      m_u = m_refq + 32768;
      m_L = 0;
      for (int k = 0; k < 4; k++) if (m_u > k * 16384 + m_tri) m_L++;
      mtgt[0] = (m_lvl > 0) ? 1 : 0;
      mtgt[1] = (m_lvl < 0) ? 1 : 0;
      mtgt[2] = (m_lvl == 2) ? 1 : 0;
      mtgt[3] = (m_lvl == -2) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
        if (head[i] != mtgt[i]) begin
          head[i] = mtgt[i];
          tchg[i] = edge_n;
          tdt[i]  = int'(deadtime);
        end
      end
      m_step = int'(carrier_step);
      m_sync = 1'b0;
      m_turn = 1'b0;
      if (m_up) begin
        if (m_tri + m_step >= 16383) begin m_tri = 16383; m_up = 1'b0; m_turn = 1'b1; end
        else m_tri = m_tri + m_step;
      end else begin
        if (m_tri <= m_step) begin m_tri = 0; m_up = 1'b1; m_sync = 1'b1; m_turn = 1'b1; end
        else m_tri = m_tri - m_step;
      end
      if (m_turn) m_refq = int'(ref_in);
      m_lvl = m_L - 2;
    end
    model_valid = 1'b1;
  end

  function automatic int exp_pwm();
    int p = 0;
    for (int i = 0; i < 4; i++) begin
      if (head[i] >= 0 && (edge_n - tchg[i]) > tdt[i]) begin
        if (head[i] == 1) p |= (1 << (2 * i));
        else              p |= (1 << (2 * i + 1));
      end
    end
    return p;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("pwm_out", int'(pwm_out), exp_pwm());
      check("level_out", int'(level_out), m_lvl);
      check("carrier_sync", int'(carrier_sync), int'(m_sync));
      for (int i = 0; i < 4; i++)
        check("leg_overlap", int'(pwm_out[2*i] & pwm_out[2*i+1]), 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int first_sync, cnt, per;
  bit seen [5];

  initial begin
    rst = 1'b1; enable = 1'b0; ref_in = 16'sd0; carrier_step = 14'd4096; deadtime = 8'd10;
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(pwm_out), 0);
    check("reset_level", int'(level_out), 0);
    check("reset_sync", int'(carrier_sync), 0);

    // Startup with ref=0, deadtime=10: 11 dead clocks then all lower gates.
    rst = 1'b0; enable = 1'b1;
    first_sync = -1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      check("startup_dead", int'(pwm_out), 0);
      if (carrier_sync && first_sync < 0) first_sync = i;
    end
    @(negedge clk);
    check("startup_lower_on", int'(pwm_out), 8'hAA);
    check("first_valley_edge", first_sync, 7);

    // Carrier period at step 4096 is 8 clocks.
    cnt = 0;
    while (!carrier_sync && cnt < 40) begin @(negedge clk); cnt++; end
    check("sync_found", int'(carrier_sync), 1);
    per = 0;
    do begin @(negedge clk); per++; end while (!carrier_sync && per < 40);
    check("sync_period", per, 8);

    // Level 0 -> +1/+2 with deadtime=5: H1A lower falls, upper rises 6 clks later.
    deadtime = 8'd5;
    ref_in = 16'sd32767;
    cnt = 0;
    while (pwm_out[1] && cnt < 40) begin @(negedge clk); cnt++; end
    check("h1a_lower_fell", int'(pwm_out[1]), 0);
    per = 0;
    while (!pwm_out[0] && per < 40) begin @(negedge clk); per++; end
    check("deadtime_gap", per, 6);

    // Full positive reference: H1 pinned at +1, level alternates +1/+2.
    repeat (40) @(negedge clk);
    seen[3] = 1'b0; seen[4] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("pos_h1", int'(pwm_out[3:0]), 4'b1001);
      if (level_out == 3'sd1) seen[3] = 1'b1;
      if (level_out == 3'sd2) seen[4] = 1'b1;
    end
    check("pos_seen_p1", int'(seen[3]), 1);
    check("pos_seen_p2", int'(seen[4]), 1);

    // Full negative reference: both bridges at -1.
    ref_in = -16'sd32768;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("neg_pwm", int'(pwm_out), 8'h66);
      check("neg_level", int'(level_out), -2);
    end

    // Reset in the middle of a dead-time interval, then restart.
    deadtime = 8'd20;
    ref_in = 16'sd0;
    cnt = 0;
    while (level_out != 3'sd0 && cnt < 40) begin @(negedge clk); cnt++; end
    check("mid_dt_level_reached", int'(level_out), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_pwm", int'(pwm_out), 0);
    check("rst_abort_sync", int'(carrier_sync), 0);
    rst = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      check("restart_dead", int'(pwm_out), 0);
    end
    @(negedge clk);
    check("restart_on", int'(pwm_out), 8'hAA);

    // Enable drop in the middle of a dead-time interval, then restart.
    ref_in = -16'sd32768;
    cnt = 0;
    while (level_out != -3'sd2 && cnt < 40) begin @(negedge clk); cnt++; end
    check("neg_level_reached", int'(level_out), -2);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("dis_pwm", int'(pwm_out), 0);
    check("dis_level", int'(level_out), 0);
    enable = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      check("reen_dead", int'(pwm_out), 0);
    end
    @(negedge clk);
    check("reen_partial_on", int'(pwm_out), 8'h22);

    // Randomized operation against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) ref_in = 16'($urandom);
      if ($urandom_range(0, 49) == 0)
        carrier_step = ($urandom_range(0, 9) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
      if ($urandom_range(0, 49) == 0) deadtime = 8'($urandom_range(0, 12));
      rst = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 99) != 0);
    end

    // Slow reference sweep up and down: every level must appear.
    rst = 1'b0; enable = 1'b1; carrier_step = 14'd2048; deadtime = 8'd2;
    for (int i = 0; i < 5; i++) seen[i] = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      ref_in = (i < 2048) ? 16'(-32768 + i * 32) : 16'(32767 - (i - 2048) * 32);
      @(negedge clk);
      seen[int'(level_out) + 2] = 1'b1;
    end
    for (int i = 0; i < 5; i++) check("sweep_level_seen", int'(seen[i]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cascaded_pwm_modulator.md
Name: cascaded_pwm_modulator

Overview:
Downstream consumer of the sine reference generator. Converts the signed 16-bit modulation reference into gate drive for the two cascaded H-bridges of the 5-level inverter, using level-shifted triangular carrier PWM. Contains:
- a triangle carrier generator,
- a reference sample/hold,
- four band comparators,
- a level-to-bridge-state decoder,
- per-leg complementary outputs with programmable dead time.

The eight gate signals go to the gate-driver pins.

Parameters:
DATA_WIDTH, 16, width of signed reference input.
CARRIER_WIDTH, 14, triangle amplitude bits; carrier band height = 2^CARRIER_WIDTH (16384).
DT_WIDTH, 8, dead-time counter width.

Ports:
clk  in  1  system clock (100 MHz).
rst  in  1  synchronous active-high reset.
enable  in  1  modulator run; low forces all gates off.
ref_in  in  DATA_WIDTH  signed reference (-32768..+32767), e.g. sine_out.
carrier_step  in  CARRIER_WIDTH  triangle increment per clock; 0 freezes the carrier.
deadtime  in  DT_WIDTH  dead time in clocks.
pwm_out  out  8  gates: [0]/[1] H1 legA upper/lower, [2]/[3] H1 legB upper/lower, [4]/[5] H2 legA upper/lower, [6]/[7] H2 legB upper/lower.
level_out  out  3  signed output level -2..+2 (decoded target, before dead time).
carrier_sync  out  1  one-clock pulse at each carrier valley.

Behaviour:
- Reset (rst=1 at a clk edge): tri=0, dir=up, ref_q=0, comparators=0, all leg FSMs OFF, pwm_out=8'h00, level_out=0, carrier_sync=0.
  - Reset mid dead-time or mid-carrier aborts immediately to the reset state.
- enable=0 has the same effect as reset, except inputs are still accepted. Outputs are 0 on the first clock after enable falls.
- Carrier: tri is an unsigned CARRIER_WIDTH counter.
  - Up: if tri+step >= 16383, tri=16383 and dir=down; else tri+=step.
  - Down: if tri <= step, tri=0, dir=up, and carrier_sync=1 for that clock; else tri-=step.
  - Arithmetic is 15-bit, so no wrap is possible.
- Sampling: ref_q <= ref_in at every peak and valley turn (double-edge update). Before the first turn after enable, ref_q=0.
- Comparison:
  - u = ref_q + 32768, as a 16-bit unsigned value.
  - Carrier bands are c_k = k*16384 + tri, for k=0..3.
  - comp[k] <= (u > c_k), strict, registered.
  - L = comp0+comp1+comp2+comp3 (0..4).
  - level_out = L-2, registered together with comp.
- Bridge decode:
  - Level +2: H1=+1, H2=+1.
  - Level +1: H1=+1, H2=0.
  - Level 0: both 0.
  - Level -1: H1=-1, H2=0.
  - Level -2: both -1.
- Leg target states:
  - Bridge +1: legA high, legB low.
  - Bridge 0: both legs low.
  - Bridge -1: legA low, legB high.
- Leg FSM (4 instances). States: OFF, HIGH_ON, LOW_ON, DT_TO_HIGH, DT_TO_LOW.
  - OFF: both gates 0. When enabled, go to DT_TO_<target> and load the timer with deadtime.
  - HIGH_ON/LOW_ON: upper/lower gate = 1 respectively. If the target differs, enter DT_TO_<target> with both gates 0 and the timer loaded with the current deadtime.
  - DT_TO_X: both gates 0, timer decrements. When the timer reaches 0, enter X_ON.
  - Target reversal during DT_TO_X: switch to DT_TO_other and reload the timer.
  - deadtime=0: both gates are still 0 for exactly one clock.
  - Invariant: upper and lower gates of one leg are never both 1 on any cycle.
- Latency: comp/level_out update 1 clk after the tri/ref_q change. The outgoing gate falls 1 clk after that. The incoming gate rises deadtime+1 clks after the outgoing gate falls.
- Carrier frequency = f_clk / (2*ceil(16383/step)). For example, step=82 gives about 250 kHz.

Test Plan:
1. Carrier shape: step=4096 → tri sequence 0,4096,8192,12288,16383,12287,8191,4095,0. carrier_sync pulses exactly at the 0 entries.
2. ref_in=0, deadtime=10 → level_out=0, steady pwm_out=8'b10101010 (all lower gates on). After enable, all gates stay 0 for 11 clks before the lower gates rise.
3. ref_in=-32768 → level_out=-2, steady pwm_out=8'b01100110. ref_in=+32767 → level_out alternates +1/+2 (strict compare at peak), with H1 held at pwm_out[3:0]=4'b1001.
4. Dead time: force a level 0→+1 transition with deadtime=5 → pwm_out[1] falls, then pwm_out[0] rises exactly 6 clks later. Assert no upper&lower overlap on all legs for the whole run.
5. Sine sweep: drive ref_in from sine_generator at 50 Hz with MI=32767 → level_out visits all five levels per period, symmetric about zero within one carrier period.
6. Assert rst (and separately drop enable) mid dead-time → next clock pwm_out=0, tri=0, FSMs OFF. Re-enable → normal startup through a dead-time interval.
